// File: rtl/tmds_symbol_decoder.sv
// ---------------------------------------------------------------------------
// tmds_symbol_decoder
//
// Receive-side TMDS decoder for one HDMI channel. A raw, unaligned 10-bit
// symbol arrives every pixel clock from a 1:10 deserializer. A 20-bit window
// made of the current and previous symbols feeds a barrel shifter. A
// control-token search FSM walks the shifter offset until it sees a run of
// control tokens, and then holds that alignment while tokens keep arriving.
//
// Pipeline: sym_in -> sym_prev_r -> aligned_r (stage 1) -> outputs (stage 2)
//
// Parameters
//   CTRL_RUN      consecutive control tokens needed to declare lock (2..255)
//   SEARCH_WIN    cycles spent on one offset before slipping (16..65535)
//   LOSS_TIMEOUT  token-free cycles tolerated while locked (16..65535)
//
// Ports
//   clk        pixel clock, rising edge
//   rst        synchronous active-high reset
//   sym_in     raw deserialized symbol, bit 0 received first
//   dout       decoded data byte (0 outside locked data periods)
//   de         1 = data period, 0 = control period
//   c          control bits {C1,C0}
//   locked     alignment held
//   offset     current bit offset into the window, 0..9
//   terc4      TERC4 nibble of the last matching word
//   terc4_vld  aligned word is a valid TERC4 code
//
// Build option
//   TMDS_DEC_TERC4_EN  when defined, stage 2 also matches the aligned word
//                      against the 16 TERC4 codes; otherwise terc4 and
//                      terc4_vld are tied to 0.
// ---------------------------------------------------------------------------
module tmds_symbol_decoder #(
    parameter int CTRL_RUN     = 12,
    parameter int SEARCH_WIN   = 1024,
    parameter int LOSS_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] sym_in,
    output logic [7:0] dout,
    output logic       de,
    output logic [1:0] c,
    output logic       locked,
    output logic [3:0] offset,
    output logic [3:0] terc4,
    output logic       terc4_vld
);

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [7:0]  RUN_LAST = 8'(CTRL_RUN - 1);
    localparam logic [15:0] WIN_LAST = 16'(SEARCH_WIN - 1);
    localparam logic [15:0] LOSS_MAX = 16'(LOSS_TIMEOUT);

    // {hit, C1, C0} for the four control tokens
    function automatic logic [2:0] ctrl_match(input logic [9:0] w);
        case (w)
            10'h354: ctrl_match = 3'b1_00;
            10'h0AB: ctrl_match = 3'b1_01;
            10'h154: ctrl_match = 3'b1_10;
            10'h2AB: ctrl_match = 3'b1_11;
            default: ctrl_match = 3'b0_00;
        endcase
    endfunction

    // TMDS data decode: undo the optional inversion, then the XOR/XNOR chain
    function automatic logic [7:0] tmds_decode(input logic [9:0] w);
        logic [7:0] b;
        logic [7:0] d;
        b    = w[9] ? ~w[7:0] : w[7:0];
        d[0] = b[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = w[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
        end
        return d;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [9:0]  sym_prev_r;
    logic [9:0]  aligned_r;
    logic [19:0] window_s;
    logic [9:0]  aligned_s;
    state_t      state_r, state_s;
    logic [7:0]  run_r, run_s;
    logic [15:0] win_r, win_s;
    logic [15:0] loss_r, loss_s;
    logic [3:0]  offset_r, offset_s, offset_inc_s;
    logic        skip_r, skip_s;
    logic        ctrl_hit_s;
    logic [1:0]  ctrl_c_s;

    // Older symbol occupies the low half: bit 0 of the window is received first
    assign window_s     = {sym_in, sym_prev_r};
    assign aligned_s    = 10'(window_s >> offset_r);
    assign {ctrl_hit_s, ctrl_c_s} = ctrl_match(aligned_r);
    assign offset_inc_s = (offset_r == 4'd9) ? 4'd0 : offset_r + 4'd1;
    assign locked       = (state_r == LOCKED);
    assign offset       = offset_r;

    // Stage 1: symbol history, aligned word, FSM state and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            sym_prev_r <= 10'd0;
            aligned_r  <= 10'd0;
            state_r    <= SEARCH;
            run_r      <= 8'd0;
            win_r      <= 16'd0;
            loss_r     <= 16'd0;
            offset_r   <= 4'd0;
            skip_r     <= 1'b0;
        end else begin
            sym_prev_r <= sym_in;
            aligned_r  <= aligned_s;
            state_r    <= state_s;
            run_r      <= run_s;
            win_r      <= win_s;
            loss_r     <= loss_s;
            offset_r   <= offset_s;
            skip_r     <= skip_s;
        end
    end

    // Token search / lock tracking. skip_r marks the word that was already in
    // flight when the offset slipped, so it never counts toward a run.
    always_comb begin
        state_s  = state_r;
        run_s    = run_r;
        win_s    = win_r;
        loss_s   = loss_r;
        offset_s = offset_r;
        skip_s   = 1'b0;
        case (state_r)
            SEARCH: begin
                // lock takes priority over a simultaneous window expiry
                if (ctrl_hit_s && !skip_r && (run_r == RUN_LAST)) begin
                    state_s = LOCKED;
                    run_s   = 8'd0;
                    win_s   = 16'd0;
                    loss_s  = 16'd0;
                end else begin
                    if (ctrl_hit_s && !skip_r) begin
                        run_s = sat_inc8(run_r);
                    end else begin
                        run_s = 8'd0;
                    end
                    if (win_r == WIN_LAST) begin
                        offset_s = offset_inc_s;
                        run_s    = 8'd0;
                        win_s    = 16'd0;
                        skip_s   = 1'b1;
                    end else begin
                        win_s = sat_inc16(win_r);
                    end
                end
            end
            LOCKED: begin
                if (loss_r == LOSS_MAX) begin
                    state_s  = SEARCH;
                    offset_s = offset_inc_s;
                    run_s    = 8'd0;
                    win_s    = 16'd0;
                    loss_s   = 16'd0;
                    skip_s   = 1'b1;
                end else if (ctrl_hit_s) begin
                    loss_s = 16'd0;
                end else begin
                    loss_s = sat_inc16(loss_r);
                end
            end
            default: begin
                state_s = SEARCH;
            end
        endcase
    end

    // Stage 2: decoded outputs follow the state being entered this edge so
    // that locked and the CTRL_RUN-th token appear together.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= 8'd0;
            de   <= 1'b0;
            c    <= 2'b00;
        end else if (state_s == LOCKED) begin
            if (ctrl_hit_s) begin
                dout <= 8'd0;
                de   <= 1'b0;
                c    <= ctrl_c_s;
            end else begin
                dout <= tmds_decode(aligned_r);
                de   <= 1'b1;
                c    <= c;
            end
        end else begin
            dout <= 8'd0;
            de   <= 1'b0;
            c    <= 2'b00;
        end
    end

`ifdef TMDS_DEC_TERC4_EN
    // {hit, index} for the 16 TERC4 codes
    function automatic logic [4:0] terc4_match(input logic [9:0] w);
        case (w)
            10'h29C: terc4_match = {1'b1, 4'd0};
            10'h263: terc4_match = {1'b1, 4'd1};
            10'h2E4: terc4_match = {1'b1, 4'd2};
            10'h2E2: terc4_match = {1'b1, 4'd3};
            10'h171: terc4_match = {1'b1, 4'd4};
            10'h11E: terc4_match = {1'b1, 4'd5};
            10'h18E: terc4_match = {1'b1, 4'd6};
            10'h13C: terc4_match = {1'b1, 4'd7};
            10'h2CC: terc4_match = {1'b1, 4'd8};
            10'h139: terc4_match = {1'b1, 4'd9};
            10'h19C: terc4_match = {1'b1, 4'd10};
            10'h2C6: terc4_match = {1'b1, 4'd11};
            10'h28E: terc4_match = {1'b1, 4'd12};
            10'h271: terc4_match = {1'b1, 4'd13};
            10'h163: terc4_match = {1'b1, 4'd14};
            10'h2C3: terc4_match = {1'b1, 4'd15};
            default: terc4_match = 5'd0;
        endcase
    endfunction

    logic       terc4_hit_s;
    logic [3:0] terc4_idx_s;
    assign {terc4_hit_s, terc4_idx_s} = terc4_match(aligned_r);

    // TERC4 nibble holds its last value when the current word does not match
    always_ff @(posedge clk) begin
        if (rst) begin
            terc4     <= 4'd0;
            terc4_vld <= 1'b0;
        end else if ((state_s == LOCKED) && terc4_hit_s) begin
            terc4     <= terc4_idx_s;
            terc4_vld <= 1'b1;
        end else begin
            terc4     <= terc4;
            terc4_vld <= 1'b0;
        end
    end
`else
    assign terc4     = 4'd0;
    assign terc4_vld = 1'b0;
`endif

endmodule
